booth_r4_seq: RTL

//   Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, retiring one Booth digit per clock.

---
 rtl/booth_r4_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/booth_r4_seq.sv
// Iterative radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH, one Booth digit per clock,
// run-time signed/unsigned mode, valid/ready on both sides and a consumed-result counter.
module booth_r4_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int KW = $clog2(N) + 1;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_badWidth
        $error("booth_r4_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_a;
    logic [AW-1:0]       r_acc;
    logic [BW-1:0]       r_b;
    logic [KW-1:0]       r_k;
    logic [2*WIDTH-1:0]  r_result;
    logic [CNT_W-1:0]    r_count;

    logic [AW-1:0]       w_aExt;
    logic [BW-1:0]       w_bExt;
    logic [AW-1:0]       w_pp;
    logic [AW-1:0]       w_accNext;
    logic                w_accept;
    logic                w_consume;
    logic                w_lastDigit;

    // The two extra top bits of B give unsigned operands a final non-negative digit.
    assign w_aExt = is_signed ? {{(WIDTH + 2){multiplicand[WIDTH-1]}}, multiplicand}
                              : {{(WIDTH + 2){1'b0}}, multiplicand};
    assign w_bExt = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                              : {2'b00, multiplier, 1'b0};

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_consume   = out_ready && (r_state == S_DONE);
    assign w_lastDigit = (r_k == KW'(N - 1));
    assign w_accNext   = r_acc + w_pp;

    // r_a is pre-shifted by 2k and r_b shifted down, so the current digit is always r_b[2:0].
    always_comb begin
        w_pp = '0;
        case (r_b[2:0])
            3'b001, 3'b010: w_pp = r_a;
            3'b011:         w_pp = r_a << 1;
            3'b100:         w_pp = ~(r_a << 1) + AW'(1);
            3'b101, 3'b110: w_pp = ~r_a + AW'(1);
            default:        w_pp = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)    w_next = S_CALC;
            S_CALC:  if (w_lastDigit) w_next = S_DONE;
            S_DONE:  if (out_ready)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a   <= w_aExt;
            r_b   <= w_bExt;
            r_acc <= '0;
            r_k   <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_accNext;
            r_a   <= r_a << 2;
            r_b   <= r_b >> 2;
            r_k   <= r_k + KW'(1);
            if (w_lastDigit) begin
                r_result <= w_accNext[2*WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_consume) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_CALC);
    assign result    = r_result;
    assign op_count  = r_count;

endmodule
